shift_add_multiplier: RTL
=========================

// Module: shift_add_multiplier
// PURPOSE
//  Sequential unsigned multiplier: the multiply counterpart of the restoring divider.
//  Contains its own FSM and datapath (add/shift, iteration counter).
//  Uses a start/done handshake, one add-shift iteration per clock, WIDTH iterations.
//  Sits beside the divider in the arithmetic unit; shares the same start/done handshake style.
// PARAMETERS
//  WIDTH  8  operand width in bits (>=2); product is 2*WIDTH bits
// PORTS
//  clk      in   1        single clock, all state on rising edge
//  rst      in   1        synchronous, active-high reset
//  start    in   1        request; sampled only in IDLE
//  a_in     in   WIDTH    multiplicand, unsigned, captured on accepted start
//  b_in     in   WIDTH    multiplier, unsigned, captured on accepted start
//  busy     out  1        high in CALC and DONE
//  done     out  1        one-cycle pulse; product valid
//  product  out  2*WIDTH  result, registered, held until next accepted start
// BEHAVIOUR
//  Reset: rst sampled high at an edge -> state=IDLE; busy=0, done=0, product=0.
//   Clears the accumulator, operand registers and counter.
//   Reset takes priority over every other event. Mid-operation reset aborts with no done pulse.
//  States: IDLE, CALC, DONE (2-bit encoding; unused code -> IDLE).
//   Outputs busy/done are registered, not decoded from a partial case list.
//  IDLE: start=1 at an edge -> load mcand=a_in, mplr=b_in, acc=0, cnt=0; go to CALC.
//   start=0 -> stay in IDLE.
//  CALC, each edge:
//   - sum = {1'b0,acc} + (mplr[0] ? {1'b0,mcand} : 0), giving WIDTH+1 bits.
//   - {acc,mplr} <= {sum,mplr} >> 1, a right shift of 2*WIDTH+1 bits (the carry enters acc MSB).
//   - cnt <= cnt+1. cnt width is $clog2(WIDTH+1).
//   - On the edge completing iteration WIDTH (cnt==WIDTH-1): go to DONE.
//     On that same edge: product <= {acc_next,mplr_next}, done <= 1.
//  DONE: lasts exactly one cycle; then go to IDLE and set done <= 0.
//  Latency: start sampled at edge E0 -> done=1 and product valid after edge E0+WIDTH.
//   done drops after edge E0+WIDTH+1.
//  Throughput: the next start may be accepted at edge E0+WIDTH+2 (first IDLE cycle).
//  Handshake rules:
//   - start while busy (CALC or DONE) is ignored; it is not queued.
//   - a_in/b_in changes after capture have no effect on the result.
//   - start held high continuously -> a new operation begins each time IDLE is entered.
//  Arithmetic: product = a_in*b_in exactly; no overflow possible in 2*WIDTH bits.
//   0 operands and all-ones operands need no special case.
//  product: changes only on the DONE-entry edge or on reset; stable otherwise.
// TESTING (WIDTH=8)
//  1. rst, then start with a=13,b=11 -> done pulses 1 cycle, 8 edges after start edge.
//     product=143; busy=1 during CALC/DONE.
//  2. a=255,b=255 -> product=65025 (carry path); a=0,b=200 -> 0; a=1,b=173 -> 173.
//  3. start re-pulsed mid-CALC with a=2,b=2 -> ignored; result still from first operands.
//     Exactly one done pulse.
//  4. rst asserted at iteration 4 -> next cycle IDLE, busy=0, product=0, no done pulse.
//     A new start then gives the correct result.
//  5. start held high for 3 ops (5*7, 9*9, 200*3) -> products 35, 81, 600.
//     done pulses spaced WIDTH+2 cycles apart.
//  6. Random a,b over 1000 ops vs. reference model -> all match; product stable between dones.

Source files
------------

// File: rtl/shift_add_multiplier_if.sv
// ============================================================================
// Module      : shift_add_multiplier_if
// Description : start/done handshake bundle for the sequential multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface shift_add_multiplier_if #(
   parameter int unsigned WIDTH = 8
);
   logic                 start;
   logic [WIDTH-1:0]     a_in;
   logic [WIDTH-1:0]     b_in;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;

   modport master (
      output start,
      output a_in,
      output b_in,
      input  busy,
      input  done,
      input  product
   );

   modport slave (
      input  start,
      input  a_in,
      input  b_in,
      output busy,
      output done,
      output product
   );
endinterface

`default_nettype wire

// File: rtl/shift_add_multiplier.sv
// ============================================================================
// Module      : shift_add_multiplier
// Description : Sequential unsigned shift-add multiplier, one iteration/clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_add_multiplier #(
   parameter int unsigned WIDTH = 8
) (
   input  wire logic               clk,
   input  wire logic               rst,
   shift_add_multiplier_if.slave   bus
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplr_q,  mplr_d;
   logic [WIDTH-1:0]     acc_q,   acc_d;
   logic [CNT_W-1:0]     cnt_q,   cnt_d;
   logic                 busy_q,  busy_d;
   logic                 done_q,  done_d;
   logic [2*WIDTH-1:0]   product_q, product_d;
   logic [WIDTH:0]       sum;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         mcand_q   <= '0;
         mplr_q    <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         mplr_q    <= mplr_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         product_q <= product_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      mplr_d    = mplr_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      product_d = product_q;
      sum       = {1'b0, acc_q} + (mplr_q[0] ? {1'b0, mcand_q} : '0);

      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (bus.start) begin
               mcand_d = bus.a_in;
               mplr_d  = bus.b_in;
               acc_d   = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = CALC;
            end
         end
         CALC: begin
            // {sum,mplr} >> 1: carry lands in acc MSB, sum LSB enters mplr MSB
            {acc_d, mplr_d} = {sum, mplr_q[WIDTH-1:1]};
            cnt_d           = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               product_d = {acc_d, mplr_d};
               done_d    = 1'b1;
               state_d   = DONE;
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.product = product_q;

endmodule

`default_nettype wire
